// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM state type and default response width for the PUF response path
package puf_pkg;
    typedef enum logic {IDLE, SHIFT} state_e;
    localparam int DEFAULT_RESP_WIDTH = 16;
endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: holding register for assembled words with valid/ready handshake, sticky overrun and word counter
//   clk, rst        clock and synchronous active-high reset
//   load_i, data_i  completed word strobe and its value
//   ready_i         consumer accepts the held word
//   clr_overrun_i   clears the sticky overrun flag (a simultaneous drop wins)
//   data_o, valid_o held word and its valid flag
//   overrun_o       sticky flag: a completed word was dropped
//   count_o         number of words loaded, wraps at 16 bits
module deser_out_reg #(
    parameter int WIDTH = puf_pkg::DEFAULT_RESP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             clr_overrun_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o,
    output logic [15:0]      count_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    logic [15:0]      count_q, count_d;
    logic             take, drop;

    // A new word fits if the slot is empty or is being consumed this very cycle
    assign take = load_i && (!valid_q || ready_i);
    assign drop = load_i && valid_q && !ready_i;

    always_comb begin
        data_d    = take ? data_i : data_q;
        valid_d   = take ? 1'b1 : (valid_q && !ready_i);
        count_d   = take ? count_q + 16'd1 : count_q;
        overrun_d = drop ? 1'b1 : (clr_overrun_i ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign count_o   = count_q;
endmodule

// File: rtl/response_deserializer.sv
// response_deserializer: assembles framed serial PUF response bits into WIDTH-bit words
//   clk, rst            clock and synchronous active-high reset
//   ser_in, ser_valid   serial bit and its qualifier
//   frame_start         marks the current valid bit as bit 0 of a new word
//   par_data, par_valid assembled word and its valid flag, consumed on par_ready
//   overrun, clr_overrun sticky drop flag and its clear
//   word_count          words delivered, wraps at 16 bits
module response_deserializer
    import puf_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_RESP_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [15:0]      word_count
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        if (ser_valid) begin
            if (frame_start) begin
                // Start (or resync) a word: the partial word is discarded and this bit is bit 0
                state_d = SHIFT;
                cnt_d   = CW'(1);
                shreg_d = MSB_FIRST ? {{(WIDTH-1){1'b0}}, ser_in} : {ser_in, {(WIDTH-1){1'b0}}};
            end else if (state_q == SHIFT) begin
                // After WIDTH shifts the first bit has migrated to the MSB (or LSB)
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], ser_in} : {ser_in, shreg_q[WIDTH-1:1]};
                done    = cnt_q == CW'(WIDTH-1);
                cnt_d   = done ? '0 : cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    deser_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk           (clk),
        .rst           (rst),
        .load_i        (done),
        .data_i        (shreg_d),
        .ready_i       (par_ready),
        .clr_overrun_i (clr_overrun),
        .data_o        (par_data),
        .valid_o       (par_valid),
        .overrun_o     (overrun),
        .count_o       (word_count)
    );
endmodule

// File: doc/response_deserializer.md
RESPONSE_DESERIALIZER -- requirements
Module: response_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of response bits per assembled word (range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first serial bit lands in bit WIDTH-1, 0 = first bit lands in bit 0.
REQ-003 SHALL have port clk  input  1  single clock for all logic; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ser_in  input  1  serial response bit from the PUF shift-register output.
REQ-006 SHALL have port ser_valid  input  1  ser_in carries a valid bit this cycle.
REQ-007 SHALL have port frame_start  input  1  marks the current valid bit as bit 0 of a new word; sampled only when ser_valid=1.
REQ-008 SHALL have port par_data  output  WIDTH  assembled word.
REQ-009 SHALL have port par_valid  output  1  par_data holds an unconsumed word.
REQ-010 SHALL have port par_ready  input  1  consumer accepts the word when par_valid & par_ready.
REQ-011 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 SHALL have port clr_overrun  input  1  clears overrun.
REQ-013 SHALL have port word_count  output  16  count of words delivered to par_data, wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement FSM states IDLE (waiting for frame) and SHIFT (assembling).
REQ-015 IDLE->SHIFT SHALL occur on ser_valid & frame_start; that bit SHALL be stored as bit 0 of the word and bit counter set to 1.
REQ-016 In IDLE, ser_valid without frame_start SHALL be ignored.
REQ-017 In SHIFT, each ser_valid SHALL shift one bit in and increment the counter; cycles with ser_valid=0 SHALL hold state.
REQ-018 In SHIFT, ser_valid & frame_start SHALL discard the partial word and restart at bit 0 with that bit (resync); overrun unaffected.
REQ-019 On the WIDTH-th accepted bit the word SHALL complete; counter SHALL wrap to 0 and FSM SHALL stay in SHIFT, next valid bit starting a new word without frame_start.
REQ-020 A completed word SHALL appear on par_data with par_valid=1 the cycle after its last bit is accepted (latency 1).
REQ-021 par_valid SHALL stay high and par_data stable until par_valid & par_ready.
REQ-022 If a word completes while par_valid=1 and par_ready=0, the new word SHALL be dropped, par_data kept, overrun set.
REQ-023 If a word completes in the same cycle par_valid & par_ready, the new word SHALL load and par_valid SHALL stay 1 (no overrun).
REQ-024 word_count SHALL increment once per word loaded into par_data.
REQ-025 clr_overrun SHALL clear overrun next cycle; if a drop occurs the same cycle, set SHALL win.
REQ-026 Bit counter SHALL be $clog2(WIDTH)+1 bits wide; no other arithmetic beyond counter and word_count increments.

Reset
REQ-027 On rst=1 at a clk edge: FSM=IDLE, counter=0, shift register=0, par_data=0, par_valid=0, overrun=0, word_count=0.
REQ-028 Reset mid-word SHALL discard the partial word; reset SHALL take priority over all other inputs.
REQ-029 After reset release a frame_start SHALL be required before any bit is accepted.

Structure
REQ-030 Package puf_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and constant DEFAULT_RESP_WIDTH=16.
REQ-031 Output holding register with valid/ready and overrun logic SHALL be one sub-module, deser_out_reg; shift/count/FSM stay in the top.

Verification (WIDTH=8)
REQ-032 MSB_FIRST=1, frame_start with first bit, bits 1,0,1,0,0,1,0,1 on consecutive cycles, par_ready=1 -> par_data=0xA5, par_valid high one cycle after 8th bit, word_count=1.
REQ-033 MSB_FIRST=0, same bit stream -> par_data=0xA5 bit-reversed = 0xA5 check replaced by stream 1,0,0,0,0,0,0,0 -> 0x01 (MSB_FIRST=1 gives 0x80).
REQ-034 par_ready=0, two back-to-back words 0x3C then 0xC3 -> par_data stays 0x3C, overrun=1, word_count=1; clr_overrun -> overrun=0.
REQ-035 frame_start after 5 bits of 0xFF, then full word 0x5A -> par_data=0x5A, only one par_valid event, no overrun.
REQ-036 rst asserted after 4 bits, then ser_valid bits without frame_start -> no par_valid, all outputs 0; frame_start + 0x11 -> par_data=0x11.
REQ-037 Word completes in cycle where par_valid & par_ready -> new word loaded, par_valid continuously 1, overrun=0.
